// File: rtl/rv_gshare_predictor.sv
// rv_gshare_predictor: gshare/bimodal saturating-counter branch predictor with init sweep; RV_GSHARE_BYPASS_EN forwards same-cycle updates
module rv_gshare_predictor #(
  parameter int XLEN   = 32,
  parameter int IDX_W  = 6,
  parameter int CNT_W  = 2,
  parameter int GHR_W  = 4,
  parameter bit GSHARE = 1
) (
  input  logic             i_bp_clk,
  input  logic             i_bp_rst,
  input  logic [XLEN-1:0]  i_bp_pc_if,
  output logic             o_bp_pred_taken,
  output logic [IDX_W-1:0] o_bp_pred_idx,
  input  logic             i_bp_upd_valid,
  input  logic [IDX_W-1:0] i_bp_upd_idx,
  input  logic             i_bp_upd_taken,
  output logic             o_bp_ready
);
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] WNT = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CMAX = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t           state;
  logic [IDX_W-1:0] init_ptr;
  logic [GHR_W-1:0] ghr;
  logic [CNT_W-1:0] tbl [DEPTH];
  logic [CNT_W-1:0] upd_cnt, upd_nxt, pred_cnt;
  logic             hit;
  // index, saturating update value and prediction
  always_comb begin
    o_bp_pred_idx = i_bp_pc_if[IDX_W+1:2] ^ (GSHARE ? IDX_W'(ghr) : '0);
    upd_cnt = tbl[i_bp_upd_idx];
    upd_nxt = i_bp_upd_taken ? (upd_cnt == CMAX ? upd_cnt : upd_cnt + CNT_W'(1))
                             : (upd_cnt == '0 ? upd_cnt : upd_cnt - CNT_W'(1));
    hit = i_bp_upd_valid && state == RUN && i_bp_upd_idx == o_bp_pred_idx;
`ifdef RV_GSHARE_BYPASS_EN
    pred_cnt = hit ? upd_nxt : tbl[o_bp_pred_idx];
`else
    pred_cnt = tbl[o_bp_pred_idx];
`endif
    o_bp_pred_taken = o_bp_ready & pred_cnt[CNT_W-1];
  end
  // init sweep, then resolve-time counter and history updates
  always_ff @(posedge i_bp_clk) begin
    if (i_bp_rst) begin
      state      <= INIT;
      init_ptr   <= '0;
      ghr        <= '0;
      o_bp_ready <= 1'b0;
    end else if (state == INIT) begin
      tbl[init_ptr] <= WNT;
      init_ptr      <= init_ptr + IDX_W'(1);
      if (init_ptr == IDX_W'(DEPTH-1)) begin
        state      <= RUN;
        o_bp_ready <= 1'b1;
      end
    end else if (i_bp_upd_valid) begin
      tbl[i_bp_upd_idx] <= upd_nxt;
      ghr               <= GHR_W'({ghr, i_bp_upd_taken});
    end
  end
endmodule

// File: tb/tb_rv_gshare_predictor.sv
// tb_rv_gshare_predictor: directed checks of init, gshare/bimodal indexing, saturation, same-cycle update and mid-run reset
module tb_rv_gshare_predictor;
  logic clk = 0, rst = 0, valid = 0, taken = 0;
  logic [31:0] pc = 32'h100;
  logic [5:0] uidx = '0;
  logic pred, pred_b, ready, ready_b;
  logic [5:0] idx, idx_b;
  logic [3:0] ghr_m = '0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  rv_gshare_predictor #(.GSHARE(1)) dut (
    .i_bp_clk(clk), .i_bp_rst(rst), .i_bp_pc_if(pc), .o_bp_pred_taken(pred),
    .o_bp_pred_idx(idx), .i_bp_upd_valid(valid), .i_bp_upd_idx(uidx),
    .i_bp_upd_taken(taken), .o_bp_ready(ready));
  rv_gshare_predictor #(.GSHARE(0)) dut_b (
    .i_bp_clk(clk), .i_bp_rst(rst), .i_bp_pc_if(pc), .o_bp_pred_taken(pred_b),
    .o_bp_pred_idx(idx_b), .i_bp_upd_valid(valid), .i_bp_upd_idx(uidx),
    .i_bp_upd_taken(taken), .o_bp_ready(ready_b));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic upd(input logic [5:0] i, input logic t);
    valid = 1; uidx = i; taken = t;
    tick();
    valid = 0;
    ghr_m = {ghr_m[2:0], t};
  endtask

  task automatic test_reset();
    rst = 1; pc = 32'h100; tick(); rst = 0;
    valid = 1; uidx = 0; taken = 1;
    for (int i = 0; i < 64; i++) begin
      total++; if (ready !== 1'b0 || pred !== 1'b0) begin bad++; $display("FAIL init_cycle%0d ready=%b pred=%b want 0 0", i, ready, pred); end
      tick();
    end
    valid = 0; #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL ready_at_64 got %b want 1", ready); end
    total++; if (ready_b !== 1'b1) begin bad++; $display("FAIL ready_b_at_64 got %b want 1", ready_b); end
    total++; if (idx !== 6'd0) begin bad++; $display("FAIL init_idx got %0d want 0", idx); end
    total++; if (pred !== 1'b0) begin bad++; $display("FAIL init_pred got %b want 0", pred); end
  endtask

  task automatic test_gshare();
    upd(6'd0, 1'b1);
    pc = 32'h100; #1;
    total++; if (idx !== 6'd1) begin bad++; $display("FAIL gs_idx_100 got %0d want 1", idx); end
    total++; if (pred !== 1'b0) begin bad++; $display("FAIL gs_pred_100 got %b want 0", pred); end
    total++; if (idx_b !== 6'd0) begin bad++; $display("FAIL bi_idx_100 got %0d want 0", idx_b); end
    total++; if (pred_b !== 1'b1) begin bad++; $display("FAIL bi_pred_100 got %b want 1", pred_b); end
    pc = 32'h104; #1;
    total++; if (idx !== 6'd0) begin bad++; $display("FAIL gs_idx_104 got %0d want 0", idx); end
    total++; if (pred !== 1'b1) begin bad++; $display("FAIL gs_pred_104 got %b want 1", pred); end
    total++; if (idx_b !== 6'd1 || pred_b !== 1'b0) begin bad++; $display("FAIL bi_104 idx=%0d pred=%b want 1 0", idx_b, pred_b); end
  endtask

  task automatic test_saturation();
    logic [7:0] seq_t = 8'b11110000;
    logic [7:0] seq_p = 8'b11111000;
    for (int i = 0; i < 8; i++) begin
      upd(6'd5, seq_t[7-i]);
      pc = {24'h0, 6'd5 ^ {2'b00, ghr_m}, 2'b00}; #1;
      total++; if (idx !== 6'd5 || pred !== seq_p[7-i]) begin bad++; $display("FAIL sat_step%0d idx=%0d pred=%b want 5 %b", i, idx, pred, seq_p[7-i]); end
    end
  endtask

  task automatic test_same_cycle();
    logic exp_now;
`ifdef RV_GSHARE_BYPASS_EN
    exp_now = 1'b1;
`else
    exp_now = 1'b0;
`endif
    pc = {24'h0, 6'd3 ^ {2'b00, ghr_m}, 2'b00};
    valid = 1; uidx = 6'd3; taken = 1; #1;
    total++; if (idx !== 6'd3 || pred !== exp_now) begin bad++; $display("FAIL same_cycle idx=%0d pred=%b want 3 %b", idx, pred, exp_now); end
    total++; if (idx_b !== 6'd3 || pred_b !== exp_now) begin bad++; $display("FAIL same_cycle_b idx=%0d pred=%b want 3 %b", idx_b, pred_b, exp_now); end
    tick(); valid = 0; ghr_m = {ghr_m[2:0], 1'b1};
    pc = {24'h0, 6'd3 ^ {2'b00, ghr_m}, 2'b00}; #1;
    total++; if (idx !== 6'd3 || pred !== 1'b1) begin bad++; $display("FAIL after_update idx=%0d pred=%b want 3 1", idx, pred); end
  endtask

  task automatic test_mid_reset();
    upd(6'd2, 1'b1);
    upd(6'd2, 1'b1);
    pc = {24'h0, 6'd2 ^ {2'b00, ghr_m}, 2'b00}; #1;
    total++; if (idx !== 6'd2 || pred !== 1'b1) begin bad++; $display("FAIL trained idx=%0d pred=%b want 2 1", idx, pred); end
    rst = 1; tick(); rst = 0; ghr_m = '0;
    valid = 1; uidx = 6'd2; taken = 1;
    for (int i = 0; i < 64; i++) begin
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL rerun_init%0d ready=%b want 0", i, ready); end
      tick();
    end
    valid = 0; pc = 32'h8; #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL rerun_ready got %b want 1", ready); end
    total++; if (idx !== 6'd2 || pred !== 1'b0) begin bad++; $display("FAIL rerun_entry2 idx=%0d pred=%b want 2 0", idx, pred); end
  endtask

  initial begin
    test_reset();
    test_gshare();
    test_saturation();
    test_same_cycle();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
